// File: rtl/normalizer_seq_pkg.sv
// Shared definitions for the sequential normalizer.
// State encoding and default stage count.
package normalizer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Binary-search stages for the default 32-bit lane.
  localparam int LOG2_W = $clog2(32);

endpackage

// File: rtl/normalizer_seq_norm_stage.sv
// One binary-search normalize stage.
// Combinational; reused every cycle by the top.
module normalizer_seq_norm_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6,
  parameter int STEP_W     = 3
) (
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic [STEP_W-1:0]     stage_i,
  input  logic                  tc_i,
  output logic [DATA_WIDTH-1:0] value_o,
  output logic [CNT_WIDTH-1:0]  add_o
);

  int                    k;
  logic [DATA_WIDTH-1:0] top;
  logic [DATA_WIDTH-1:0] ones;
  logic                  hit;

  // Test the top K (unsigned) or K+1 (signed) bits and shift by K on a hit.
  always_comb begin
    k    = DATA_WIDTH >> (int'(stage_i) + 1);
    ones = '1;
    top  = '0;
    hit  = 1'b0;
    if (tc_i) begin
      top = value_i >> (DATA_WIDTH - k - 1);
      hit = (top == '0) ||
            (top == (ones >> (DATA_WIDTH - k - 1)));
    end else begin
      top = value_i >> (DATA_WIDTH - k);
      hit = (top == '0);
    end
    value_o = hit ? (value_i << k) : value_i;
    add_o   = hit ? CNT_WIDTH'(k) : '0;
  end

endmodule

// File: rtl/normalizer_seq.sv
// Sequential CLZ/CLS normalizer, one search stage per clock.
// Returns the left-normalized operand and the shift applied.
module normalizer_seq
  import normalizer_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  module_clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  data_tc_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  zero_o
);

  localparam int LW = $clog2(DATA_WIDTH);
  localparam int SW = (LW > 1) ? $clog2(LW) : 1;
  localparam logic [SW-1:0] LAST = SW'(LW - 1);

  state_e                state_q, state_d;
  logic [SW-1:0]         step_q, step_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  tc_q, tc_d;
  logic                  zero_q, zero_d;

  logic [DATA_WIDTH-1:0] stage_val;
  logic [CNT_WIDTH-1:0]  stage_add;
  logic                  accept;
  logic                  dp_en;
  logic                  zero_in;

  normalizer_seq_norm_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .STEP_W     (SW)
  ) u_stage (
    .value_i (data_q),
    .stage_i (step_q),
    .tc_i    (tc_q),
    .value_o (stage_val),
    .add_o   (stage_add)
  );

  assign ready_o = (state_q == IDLE) ||
                   ((state_q == DONE) && ready_i);
  assign accept  = valid_i && ready_o;
  // Datapath enable: frozen while idle with nothing offered.
  assign dp_en   = (state_q != IDLE) || valid_i;
  assign zero_in = data_tc_i ? ((a_i == '0) || (&a_i))
                             : (a_i == '0);

  assign valid_o  = (state_q == DONE);
  assign result_o = data_q;
  assign count_o  = count_q;
  assign zero_o   = zero_q;

  // Next-state and datapath update; a load overrides everything.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    data_d  = data_q;
    count_d = count_q;
    tc_d    = tc_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        data_d  = stage_val;
        count_d = count_q + stage_add;
        step_d  = step_q + 1'b1;
        if (step_q == LAST) begin
          state_d = DONE;
          // Search tops out at W-1; an all-zero word is W.
          if (zero_q && !tc_q)
            count_d = CNT_WIDTH'(DATA_WIDTH);
        end
      end
      DONE: begin
        if (ready_i && !valid_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = SHIFT;
      step_d  = '0;
      data_d  = a_i;
      count_d = '0;
      tc_d    = data_tc_i;
      zero_d  = zero_in;
    end
  end

  // Control state register.
  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers, only clocked when enabled.
  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else if (dp_en) begin
      step_q  <= step_d;
      data_q  <= data_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      zero_q  <= zero_d;
    end
  end

endmodule
